// File: rtl/bomb_scheduler_pkg.sv
// Shared types for the bomb scheduler: owner encoding, slot FSM states and
// the default coordinate width.
package momentum_pkg;
  typedef enum logic {OWNER_RED = 1'b0, OWNER_BLUE = 1'b1} owner_t;
  typedef enum logic [1:0] {IDLE, ARMED, PENDING, COOLDOWN} slot_state_t;
  localparam int POS_W = 6;
endpackage

// File: rtl/bomb_scheduler_if.sv
// Explode channel between the bomb scheduler (master) and the stun detector
// (slave). Payload is held stable while explode_valid waits for explode_ready.
interface bomb_scheduler_if import momentum_pkg::*; #(
  parameter int POS_W = momentum_pkg::POS_W
) ();
  logic             explode_valid;
  logic             explode_ready;
  owner_t           explode_owner;
  logic [POS_W-1:0] explode_x;
  logic [POS_W-1:0] explode_y;
  logic             bomb_exploded;

  modport master (output explode_valid, explode_owner, explode_x, explode_y,
                  bomb_exploded, input explode_ready);
  modport slave  (input explode_valid, explode_owner, explode_x, explode_y,
                  bomb_exploded, output explode_ready);
endinterface

// File: rtl/bomb_scheduler_slot.sv
// One player's bomb: placement latch, fuse countdown, pending request and
// cooldown. Counters only decrement while nonzero, so they never wrap.
module bomb_slot import momentum_pkg::*; #(
  parameter int FUSE_TICKS     = 150000000,
  parameter int COOLDOWN_TICKS = 100000000,
  parameter int CNT_W          = 28,
  parameter int POS_W          = momentum_pkg::POS_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             place_req,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic             grant,
  input  logic             chain_trigger,
  output logic             place_ack,
  output logic             active,
  output logic             pend_req,
  output logic [POS_W-1:0] bomb_x,
  output logic [POS_W-1:0] bomb_y
);
  localparam logic [CNT_W-1:0] FUSE_LOAD = CNT_W'(FUSE_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_TICKS - 1);

  slot_state_t      state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             accept;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state, counter update and acceptance decode
  always_comb begin
    stateNext = state;
    cntNext   = (cnt != '0) ? cnt - 1'b1 : cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (place_req) begin
          accept    = 1'b1;
          stateNext = ARMED;
          cntNext   = FUSE_LOAD;
        end
      end
      ARMED: begin
        // A neighbouring blast cuts the fuse short.
        if (chain_trigger) begin
          stateNext = PENDING;
          cntNext   = '0;
        end else if (cnt == '0) begin
          stateNext = PENDING;
        end
      end
      PENDING: begin
        if (grant) begin
          stateNext = COOLDOWN;
          cntNext   = COOL_LOAD;
        end
      end
      COOLDOWN: if (cnt == '0) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Counter, ack pulse and position latch (held through cooldown)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      place_ack <= 1'b0;
      bomb_x    <= '0;
      bomb_y    <= '0;
    end else begin
      cnt       <= cntNext;
      place_ack <= accept;
      if (accept) begin
        bomb_x <= pos_x;
        bomb_y <= pos_y;
      end
    end
  end

  assign active   = (state == ARMED) || (state == PENDING);
  assign pend_req = (state == PENDING);
endmodule

// File: rtl/bomb_scheduler.sv
// Bomb scheduler top: two bomb slots (index 0 = red, 1 = blue) feeding a
// round-robin arbiter whose output register drives the single explode channel.
// Optional chain detonation is enabled with the BOMB_CHAIN_EN macro.
module bomb_scheduler import momentum_pkg::*; #(
  parameter int FUSE_TICKS     = 150000000,
  parameter int COOLDOWN_TICKS = 100000000,
  parameter int CNT_W          = 28,
  parameter int POS_W          = momentum_pkg::POS_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             red_place_req,
  input  logic [POS_W-1:0] red_pos_x,
  input  logic [POS_W-1:0] red_pos_y,
  input  logic             blue_place_req,
  input  logic [POS_W-1:0] blue_pos_x,
  input  logic [POS_W-1:0] blue_pos_y,
  output logic             red_place_ack,
  output logic             blue_place_ack,
  output logic             red_bomb_active,
  output logic             blue_bomb_active,
  output logic [POS_W-1:0] red_bomb_x,
  output logic [POS_W-1:0] red_bomb_y,
  output logic [POS_W-1:0] blue_bomb_x,
  output logic [POS_W-1:0] blue_bomb_y,
  bomb_scheduler_if.master ex
);
  logic [1:0]            placeReq, placeAck, active, pend, grant, chainTrig;
  logic [1:0][POS_W-1:0] posX, posY, slotX, slotY;
  owner_t                lastOwner;
  logic                  hs, winBlue;

  assign placeReq = {blue_place_req, red_place_req};
  assign posX     = {blue_pos_x, red_pos_x};
  assign posY     = {blue_pos_y, red_pos_y};

  assign red_place_ack    = placeAck[0];
  assign blue_place_ack   = placeAck[1];
  assign red_bomb_active  = active[0];
  assign blue_bomb_active = active[1];
  assign red_bomb_x       = slotX[0];
  assign red_bomb_y       = slotY[0];
  assign blue_bomb_x      = slotX[1];
  assign blue_bomb_y      = slotY[1];

  assign hs    = ex.explode_valid & ex.explode_ready;
  assign grant = !hs ? 2'b00 : (ex.explode_owner == OWNER_BLUE) ? 2'b10 : 2'b01;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_slot
      bomb_slot #(
        .FUSE_TICKS(FUSE_TICKS), .COOLDOWN_TICKS(COOLDOWN_TICKS),
        .CNT_W(CNT_W), .POS_W(POS_W)
      ) u_slot (
        .clk(clk), .resetn(resetn),
        .place_req(placeReq[i]), .pos_x(posX[i]), .pos_y(posY[i]),
        .grant(grant[i]), .chain_trigger(chainTrig[i]),
        .place_ack(placeAck[i]), .active(active[i]), .pend_req(pend[i]),
        .bomb_x(slotX[i]), .bomb_y(slotY[i])
      );
`ifdef BOMB_CHAIN_EN
      // One extra bit keeps the difference signed, so 0 and 63 are far apart.
      localparam logic signed [POS_W:0] ONE = 1;
      logic signed [POS_W:0] dx, dy;
      assign dx = $signed({1'b0, slotX[i]}) - $signed({1'b0, ex.explode_x});
      assign dy = $signed({1'b0, slotY[i]}) - $signed({1'b0, ex.explode_y});
      assign chainTrig[i] = hs && (dx >= -ONE) && (dx <= ONE) &&
                            (dy >= -ONE) && (dy <= ONE);
`else
      assign chainTrig[i] = 1'b0;
`endif
    end
  endgenerate

  // Tie goes to whoever did not explode last
  always_comb begin
    winBlue = (pend == 2'b11) ? (lastOwner == OWNER_RED) : pend[1];
  end

  // Explode output register: hold until handshake, never load on a handshake edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex.explode_valid <= 1'b0;
      ex.explode_owner <= OWNER_RED;
      ex.explode_x     <= '0;
      ex.explode_y     <= '0;
      ex.bomb_exploded <= 1'b0;
      lastOwner        <= OWNER_BLUE;
    end else begin
      ex.bomb_exploded <= 1'b0;
      if (hs) begin
        ex.explode_valid <= 1'b0;
        ex.bomb_exploded <= 1'b1;
        lastOwner        <= ex.explode_owner;
      end else if (!ex.explode_valid && (pend != 2'b00)) begin
        ex.explode_valid <= 1'b1;
        ex.explode_owner <= winBlue ? OWNER_BLUE : OWNER_RED;
        ex.explode_x     <= slotX[winBlue];
        ex.explode_y     <= slotY[winBlue];
      end
    end
  end
endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler with FUSE_TICKS=4, COOLDOWN_TICKS=3.
// Edge e0 is the first edge after do_reset; checks sample 1 ns after an edge.
module tb_bomb_scheduler;
  import momentum_pkg::*;

  logic       clk, resetn;
  logic       red_place_req, blue_place_req;
  logic [5:0] red_pos_x, red_pos_y, blue_pos_x, blue_pos_y;
  logic       red_place_ack, blue_place_ack, red_bomb_active, blue_bomb_active;
  logic [5:0] red_bomb_x, red_bomb_y, blue_bomb_x, blue_bomb_y;
  int errors = 0;
  int checks = 0;

  bomb_scheduler_if #(.POS_W(6)) ifc ();

  bomb_scheduler #(.FUSE_TICKS(4), .COOLDOWN_TICKS(3), .CNT_W(4), .POS_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .red_place_req(red_place_req), .red_pos_x(red_pos_x), .red_pos_y(red_pos_y),
    .blue_place_req(blue_place_req), .blue_pos_x(blue_pos_x), .blue_pos_y(blue_pos_y),
    .red_place_ack(red_place_ack), .blue_place_ack(blue_place_ack),
    .red_bomb_active(red_bomb_active), .blue_bomb_active(blue_bomb_active),
    .red_bomb_x(red_bomb_x), .red_bomb_y(red_bomb_y),
    .blue_bomb_x(blue_bomb_x), .blue_bomb_y(blue_bomb_y),
    .ex(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b0; red_place_req = 1'b0; blue_place_req = 1'b0;
    ifc.explode_ready = 1'b1;
    ticks(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; red_place_req = 1'b1; blue_place_req = 1'b1;
    red_pos_x = 6'd7; red_pos_y = 6'd7; blue_pos_x = 6'd9; blue_pos_y = 6'd9;
    ifc.explode_ready = 1'b1;
    ticks(2);
    checks++;
    if ({red_place_ack, blue_place_ack, red_bomb_active, blue_bomb_active,
         ifc.explode_valid, ifc.bomb_exploded} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {red_place_ack, blue_place_ack, red_bomb_active, blue_bomb_active,
         ifc.explode_valid, ifc.bomb_exploded});
    end
    checks++;
    if ({red_bomb_x, blue_bomb_y, ifc.explode_x} !== 18'd0) begin
      errors++; $display("FAIL reset_coords: got %0d/%0d/%0d want 0", red_bomb_x, blue_bomb_y, ifc.explode_x);
    end
    red_place_req = 1'b0; blue_place_req = 1'b0; resetn = 1'b1;
  endtask

  task automatic test_red_place();
    do_reset();
    red_place_req = 1'b1; red_pos_x = 6'd10; red_pos_y = 6'd12;
    tick(); // e0
    red_place_req = 1'b0;
    checks++;
    if ({red_place_ack, red_bomb_active, red_bomb_x, red_bomb_y} !== {1'b1, 1'b1, 6'd10, 6'd12}) begin
      errors++; $display("FAIL place_ack: ack=%b act=%b x=%0d y=%0d want 1 1 10 12",
        red_place_ack, red_bomb_active, red_bomb_x, red_bomb_y);
    end
    tick(); // e1
    checks++;
    if (red_place_ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b want 0", red_place_ack); end
    ticks(3); // e4
    checks++;
    if (ifc.explode_valid !== 1'b0 || red_bomb_active !== 1'b1) begin
      errors++; $display("FAIL fuse_early: valid=%b act=%b want 0 1", ifc.explode_valid, red_bomb_active);
    end
    tick(); // e5
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.explode_y, ifc.bomb_exploded}
        !== {1'b1, OWNER_RED, 6'd10, 6'd12, 1'b0}) begin
      errors++; $display("FAIL explode_offer: valid=%b own=%0d x=%0d y=%0d ex=%b want 1 0 10 12 0",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.explode_y, ifc.bomb_exploded);
    end
    red_place_req = 1'b1;
    tick(); // e6 handshake
    checks++;
    if ({ifc.explode_valid, ifc.bomb_exploded, red_bomb_active, red_place_ack} !== 4'b0100) begin
      errors++; $display("FAIL handshake: valid=%b ex=%b act=%b ack=%b want 0 1 0 0",
        ifc.explode_valid, ifc.bomb_exploded, red_bomb_active, red_place_ack);
    end
    tick(); // e7
    checks++;
    if (ifc.bomb_exploded !== 1'b0 || red_bomb_x !== 6'd10) begin
      errors++; $display("FAIL cooldown_hold: ex=%b x=%0d want 0 10", ifc.bomb_exploded, red_bomb_x);
    end
    ticks(2); // e9
    checks++;
    if (red_place_ack !== 1'b0) begin errors++; $display("FAIL cooldown_block: ack=%b want 0", red_place_ack); end
    tick(); // e10
    checks++;
    if (red_place_ack !== 1'b1) begin errors++; $display("FAIL cooldown_release: ack=%b want 1", red_place_ack); end
    red_place_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    red_place_req = 1'b1; red_pos_x = 6'd1; red_pos_y = 6'd2;
    blue_place_req = 1'b1; blue_pos_x = 6'd3; blue_pos_y = 6'd4;
    tick(); // e0
    red_place_req = 1'b0; blue_place_req = 1'b0;
    checks++;
    if ({red_place_ack, blue_place_ack} !== 2'b11) begin
      errors++; $display("FAIL sim_acks: got %b want 11", {red_place_ack, blue_place_ack});
    end
    ticks(5); // e5
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x} !== {1'b1, OWNER_RED, 6'd1}) begin
      errors++; $display("FAIL sim_first_red: valid=%b own=%0d x=%0d want 1 0 1",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x);
    end
    tick(); // e6
    checks++;
    if ({ifc.explode_valid, ifc.bomb_exploded, blue_bomb_active} !== 3'b011) begin
      errors++; $display("FAIL sim_gap: valid=%b ex=%b bact=%b want 0 1 1",
        ifc.explode_valid, ifc.bomb_exploded, blue_bomb_active);
    end
    tick(); // e7
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.explode_y}
        !== {1'b1, OWNER_BLUE, 6'd3, 6'd4}) begin
      errors++; $display("FAIL sim_second_blue: valid=%b own=%0d x=%0d y=%0d want 1 1 3 4",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.explode_y);
    end
    tick(); // e8
    checks++;
    if (ifc.bomb_exploded !== 1'b1 || blue_bomb_active !== 1'b0) begin
      errors++; $display("FAIL sim_blue_done: ex=%b bact=%b want 1 0", ifc.bomb_exploded, blue_bomb_active);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    red_place_req = 1'b1; red_pos_x = 6'd5; red_pos_y = 6'd5;
    tick(); // e0
    red_place_req = 1'b0;
    ticks(6); // e6 red handshake, last owner = red
    ticks(3); // e9 red idle again
    red_place_req = 1'b1; red_pos_x = 6'd6; red_pos_y = 6'd6;
    blue_place_req = 1'b1; blue_pos_x = 6'd7; blue_pos_y = 6'd8;
    tick(); // e10
    red_place_req = 1'b0; blue_place_req = 1'b0;
    checks++;
    if ({red_place_ack, blue_place_ack} !== 2'b11) begin
      errors++; $display("FAIL rr_acks: got %b want 11", {red_place_ack, blue_place_ack});
    end
    ticks(5); // e15
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x} !== {1'b1, OWNER_BLUE, 6'd7}) begin
      errors++; $display("FAIL rr_blue_first: valid=%b own=%0d x=%0d want 1 1 7",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x);
    end
    ticks(2); // e17
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x} !== {1'b1, OWNER_RED, 6'd6}) begin
      errors++; $display("FAIL rr_red_second: valid=%b own=%0d x=%0d want 1 0 6",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    ifc.explode_ready = 1'b0;
    red_place_req = 1'b1; red_pos_x = 6'd20; red_pos_y = 6'd21;
    tick(); // e0
    red_place_req = 1'b0;
    ticks(5); // e5
    blue_place_req = 1'b1; blue_pos_x = 6'd40; blue_pos_y = 6'd41;
    tick(); // e6
    blue_place_req = 1'b0;
    checks++;
    if (blue_place_ack !== 1'b1) begin errors++; $display("FAIL bp_blue_ack: got %b want 1", blue_place_ack); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.explode_y, ifc.bomb_exploded}
          !== {1'b1, OWNER_RED, 6'd20, 6'd21, 1'b0}) begin
        errors++; $display("FAIL bp_stable[%0d]: valid=%b own=%0d x=%0d y=%0d ex=%b want 1 0 20 21 0", i,
          ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.explode_y, ifc.bomb_exploded);
      end
    end
    checks++;
    if ({red_bomb_active, blue_bomb_active} !== 2'b11) begin
      errors++; $display("FAIL bp_both_pending: got %b want 11", {red_bomb_active, blue_bomb_active});
    end
    ifc.explode_ready = 1'b1;
    tick();
    checks++;
    if ({ifc.explode_valid, ifc.bomb_exploded} !== 2'b01) begin
      errors++; $display("FAIL bp_release: valid=%b ex=%b want 0 1", ifc.explode_valid, ifc.bomb_exploded);
    end
    tick();
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x} !== {1'b1, OWNER_BLUE, 6'd40}) begin
      errors++; $display("FAIL bp_blue_next: valid=%b own=%0d x=%0d want 1 1 40",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x);
    end
    tick();
  endtask

  task automatic test_replace();
    do_reset();
    red_place_req = 1'b1; red_pos_x = 6'd30; red_pos_y = 6'd31;
    tick(); // e0
    red_pos_x = 6'd1; red_pos_y = 6'd1;
    ticks(2); // e2, still requesting while armed
    checks++;
    if ({red_place_ack, red_bomb_x, red_bomb_y} !== {1'b0, 6'd30, 6'd31}) begin
      errors++; $display("FAIL replace_armed: ack=%b x=%0d y=%0d want 0 30 31", red_place_ack, red_bomb_x, red_bomb_y);
    end
    red_place_req = 1'b0;
    ticks(4); // e6 handshake
    red_place_req = 1'b1; red_pos_x = 6'd2; red_pos_y = 6'd2;
    ticks(2); // e8 in cooldown
    checks++;
    if ({red_place_ack, red_bomb_x, red_bomb_active} !== {1'b0, 6'd30, 1'b0}) begin
      errors++; $display("FAIL replace_cooldown: ack=%b x=%0d act=%b want 0 30 0", red_place_ack, red_bomb_x, red_bomb_active);
    end
    red_place_req = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    red_place_req = 1'b1; red_pos_x = 6'd5; red_pos_y = 6'd5;
    tick(); // e0
    red_place_req = 1'b0;
    ticks(9); // e9: red exploded at e6, now idle, last owner = red
    ifc.explode_ready = 1'b0;
    blue_place_req = 1'b1; blue_pos_x = 6'd9; blue_pos_y = 6'd9;
    tick(); // e10
    blue_place_req = 1'b0;
    tick(); // e11
    red_place_req = 1'b1; red_pos_x = 6'd8; red_pos_y = 6'd8;
    tick(); // e12
    red_place_req = 1'b0;
    ticks(3); // e15: blue offered, red armed
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, red_bomb_active} !== {1'b1, OWNER_BLUE, 1'b1}) begin
      errors++; $display("FAIL mr_setup: valid=%b own=%0d ract=%b want 1 1 1",
        ifc.explode_valid, ifc.explode_owner, red_bomb_active);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x, ifc.bomb_exploded, red_bomb_active,
         blue_bomb_active, red_bomb_x, blue_bomb_x} !== 22'd0) begin
      errors++; $display("FAIL mr_cleared: valid=%b own=%0d x=%0d ract=%b bact=%b rx=%0d bx=%0d want all 0",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x, red_bomb_active, blue_bomb_active, red_bomb_x, blue_bomb_x);
    end
    resetn = 1'b1; ifc.explode_ready = 1'b1;
    red_place_req = 1'b1; red_pos_x = 6'd1; red_pos_y = 6'd1;
    blue_place_req = 1'b1; blue_pos_x = 6'd2; blue_pos_y = 6'd2;
    tick(); // e0
    red_place_req = 1'b0; blue_place_req = 1'b0;
    ticks(5); // e5
    checks++;
    if ({ifc.explode_valid, ifc.explode_owner, ifc.explode_x} !== {1'b1, OWNER_RED, 6'd1}) begin
      errors++; $display("FAIL mr_red_tie: valid=%b own=%0d x=%0d want 1 0 1",
        ifc.explode_valid, ifc.explode_owner, ifc.explode_x);
    end
    ticks(3);
  endtask

  task automatic test_chain();
    int vec [3][5];
    logic expChain;
    // red x, red y, blue x, blue y, blast reaches blue
    vec = '{'{10, 12, 11, 13, 1}, '{10, 12, 12, 12, 0}, '{0, 0, 63, 0, 0}};
    for (int v = 0; v < 3; v++) begin
`ifdef BOMB_CHAIN_EN
      expChain = (vec[v][4] != 0);
`else
      expChain = 1'b0;
`endif
      do_reset();
      red_place_req = 1'b1; red_pos_x = 6'(vec[v][0]); red_pos_y = 6'(vec[v][1]);
      tick(); // e0
      red_place_req = 1'b0;
      ticks(3); // e3
      blue_place_req = 1'b1; blue_pos_x = 6'(vec[v][2]); blue_pos_y = 6'(vec[v][3]);
      tick(); // e4
      blue_place_req = 1'b0;
      ticks(3); // e7: red handshake was e6
      checks++;
      if (ifc.explode_valid !== expChain) begin
        errors++; $display("FAIL chain_early[%0d]: valid=%b want %b", v, ifc.explode_valid, expChain);
      end
      ticks(2); // e9: normal fuse offer time for blue
      checks++;
      if (ifc.explode_valid !== !expChain) begin
        errors++; $display("FAIL chain_late[%0d]: valid=%b want %b", v, ifc.explode_valid, !expChain);
      end
      ticks(2);
    end
  endtask

  initial begin
    ifc.explode_ready = 1'b1;
    red_pos_x = '0; red_pos_y = '0; blue_pos_x = '0; blue_pos_y = '0;
    test_reset();
    test_red_place();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_replace();
    test_mid_reset();
    test_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
